product_deskew: RTL and testbench

// - Sits directly downstream of the pipelined multiplier.
// - The multiplier emits product bit k (k < LOW) one cycle after bit k-1.

---
 rtl/product_deskew_if.sv | 24 ++
 rtl/product_deskew.sv | 104 ++++++++++
 tb/tb_product_deskew.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/product_deskew_if.sv
// Handshake bundle between the multiplier/consumer side and product_deskew.
interface product_deskew_if #(
   parameter int unsigned WIDTH = 2
) ();
   logic             en;
   logic             in_valid;
   logic [WIDTH-1:0] in;
   logic             up_en;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out;

   // Driver side: the multiplier feeding bits in and the consumer taking words out.
   modport master (
      output en, in_valid, in, out_ready,
      input  up_en, out_valid, out
   );

   // The deskew block itself.
   modport slave (
      input  en, in_valid, in, out_ready,
      output up_en, out_valid, out
   );
endinterface

// File: rtl/product_deskew.sv
// Realigns the staggered low bits of a pipelined multiplier into whole product words
// and buffers them in a 2-entry valid/ready queue. up_en freezes the multiplier
// whenever the queue cannot take the next word.
module product_deskew #(
   parameter int unsigned WIDTH = 2,
   parameter int unsigned LOW   = 1
) (
   input logic             clk,
   input logic             rst,
   product_deskew_if.slave bus
);

   logic             advance;
   logic             aligned_valid;
   logic [WIDTH-1:0] aligned;
   logic             push;
   logic             pop;

   logic [WIDTH-1:0] mem_q [2];
   logic             rd_ptr_q;
   logic             wr_ptr_q;
   logic [1:0]       count_q;
   logic [1:0]       count_d;

   // A full queue with no pop this cycle stalls the whole deskew path and the multiplier.
   assign advance = bus.en & ((count_q < 2'd2) | bus.out_ready);
   assign push    = advance & aligned_valid;
   assign pop     = (count_q != 2'd0) & bus.out_ready;

   // Bit k below LOW-1 waits LOW-1-k advancing cycles; the rest pass straight through.
   for (genvar k = 0; k < int'(WIDTH); k++) begin : g_bit
      if (k < int'(LOW) - 1) begin : g_dly
         localparam int Depth = int'(LOW) - 1 - k;
         logic [Depth-1:0] sh_q;

         // Delay line for bit k, newest sample in bit 0.
         always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
               sh_q <= '0;
            end else if (advance) begin
               sh_q <= (sh_q << 1) | Depth'(bus.in[k]);
            end
         end

         assign aligned[k] = sh_q[Depth-1];
      end else begin : g_thru
         assign aligned[k] = bus.in[k];
      end
   end

   // in_valid marks bit 0, so it rides the same LOW-1 stages as bit 0.
   if (LOW > 1) begin : g_vpipe
      localparam int VpDepth = int'(LOW) - 1;
      logic [VpDepth-1:0] vp_q;

      // Valid pipe, shifts only when the deskew path advances.
      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            vp_q <= '0;
         end else if (advance) begin
            vp_q <= (vp_q << 1) | VpDepth'(bus.in_valid);
         end
      end

      assign aligned_valid = vp_q[VpDepth-1];
   end else begin : g_novpipe
      assign aligned_valid = bus.in_valid;
   end

   // Occupancy next state; push at count 2 only happens alongside a pop.
   always_comb begin
      count_d = count_q;
      unique case ({push, pop})
         2'b10:   count_d = count_q + 2'd1;
         2'b01:   count_d = count_q - 2'd1;
         default: count_d = count_q;
      endcase
   end

   // Two-entry ring buffer holding aligned words until the consumer takes them.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         mem_q[0] <= '0;
         mem_q[1] <= '0;
         rd_ptr_q <= 1'b0;
         wr_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         if (push) begin
            mem_q[wr_ptr_q] <= aligned;
            wr_ptr_q        <= ~wr_ptr_q;
         end
         if (pop) begin
            rd_ptr_q <= ~rd_ptr_q;
         end
         count_q <= count_d;
      end
   end

   assign bus.up_en     = advance;
   assign bus.out_valid = (count_q != 2'd0);
   assign bus.out       = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_product_deskew.sv
// Bench for product_deskew: acts as the staggering multiplier, keeps a queue model of
// the expected output stream, and checks outputs every cycle plus literal spot checks.
module tb_product_deskew;
   localparam int unsigned W = 8;
   localparam int unsigned L = 4;
   localparam int          N = 512;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   product_deskew_if #(.WIDTH(W)) bus ();
   product_deskew_if #(.WIDTH(2)) bus2 ();

   product_deskew #(.WIDTH(W), .LOW(L)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   product_deskew #(.WIDTH(2), .LOW(1)) dut2 (
      .clk (clk),
      .rst (rst),
      .bus (bus2)
   );

   int vectors    = 0;
   int miscompares = 0;

   // Stimulus schedule indexed by upstream advance count (the multiplier's own time).
   logic [W-1:0] drv      [N];
   logic         vld      [N];
   logic         has_prod [N];
   logic [W-1:0] prod_at  [N];
   int           acnt = 0;

   // Expected contents of the output queue, head first.
   logic [W-1:0] mq [$];

   assign bus.in       = drv[acnt];
   assign bus.in_valid = vld[acnt];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_stim();
      for (int i = 0; i < N; i++) begin
         drv[i]      = '0;
         vld[i]      = 1'b0;
         has_prod[i] = 1'b0;
         prod_at[i]  = '0;
      end
   endtask

   // Schedule product p as the multiplier would emit it, starting at the current slot.
   task automatic inject(input logic [W-1:0] p);
      int guard = 0;
      int idx;
      while (has_prod[acnt] && guard < 20) begin
         tick();
         guard++;
      end
      check("inject_slot_free", 32'(has_prod[acnt]), 32'd0);
      has_prod[acnt] = 1'b1;
      prod_at[acnt]  = p;
      vld[acnt]      = 1'b1;
      for (int k = 0; k < int'(W); k++) begin
         idx = acnt + ((k < int'(L) - 1) ? k : int'(L) - 1);
         drv[idx][k] = p[k];
      end
   endtask

   // Tick until out_valid appears (bounded) and check latency and value.
   task automatic wait_lat(input int start_n, input int exp_n, input logic [W-1:0] exp_p);
      int n = start_n;
      bit found = 1'b0;
      while (!found && n < 20) begin
         tick();
         n++;
         @(negedge clk);
         if (bus.out_valid === 1'b1) found = 1'b1;
      end
      check("latency", 32'(n), 32'(exp_n));
      check("latency_value", 32'(bus.out), 32'(exp_p));
   endtask

   // Reference model: a word completes once its last stagger slot is passed by an advance.
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mq.delete();
         acnt <= 0;
      end else begin
         logic exp_adv;
         exp_adv = bus.en & ((mq.size() < 2) | bus.out_ready);
         if (mq.size() > 0 && bus.out_ready) void'(mq.pop_front());
         if (exp_adv) begin
            if (acnt >= int'(L) - 1 && has_prod[acnt - (int'(L) - 1)]) begin
               mq.push_back(prod_at[acnt - (int'(L) - 1)]);
            end
            acnt <= acnt + 1;
         end
      end
   end

   // Per-cycle comparison against the model.
   always @(negedge clk) begin
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) check("out", 32'(bus.out), 32'(mq[0]));
      if (!rst) check("out_in_reset", 32'(bus.out), 32'd0);
      check("up_en", 32'(bus.up_en), 32'(bus.en & ((mq.size() < 2) | bus.out_ready)));
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] b2b [3];
      logic [W-1:0] bp  [3];
      logic [W-1:0] got [$];
      int seen;

      b2b = '{8'h11, 8'h22, 8'h33};
      bp  = '{8'h81, 8'h42, 8'h24};

      clear_stim();
      bus.en         = 1'b0;
      bus.out_ready  = 1'b1;
      bus2.en        = 1'b1;
      bus2.out_ready = 1'b1;
      bus2.in        = '0;
      bus2.in_valid  = 1'b0;

      repeat (2) tick();
      @(negedge clk);
      check("reset_out_valid", 32'(bus.out_valid), 32'd0);
      check("reset_out", 32'(bus.out), 32'd0);
      tick();
      rst    = 1'b1;
      bus.en = 1'b1;
      repeat (2) tick();

      // Single staggered product, 4 advancing cycles of latency.
      inject(8'hC3);
      wait_lat(0, 4, 8'hC3);

      // Back-to-back products leave one per cycle in order.
      repeat (3) tick();
      inject(b2b[0]);
      tick();
      inject(b2b[1]);
      tick();
      inject(b2b[2]);
      tick();
      for (int j = 0; j < 3; j++) begin
         tick();
         @(negedge clk);
         check("b2b_valid", 32'(bus.out_valid), 32'd1);
         check("b2b_out", 32'(bus.out), 32'(b2b[j]));
         check("b2b_up_en", 32'(bus.up_en), 32'd1);
      end

      // Backpressure: queue fills, multiplier frozen, then drains all three.
      repeat (3) tick();
      bus.out_ready = 1'b0;
      inject(bp[0]);
      tick();
      inject(bp[1]);
      tick();
      inject(bp[2]);
      repeat (7) tick();
      @(negedge clk);
      check("bp_up_en", 32'(bus.up_en), 32'd0);
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_head", 32'(bus.out), 32'(bp[0]));
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10; i++) begin
         if (bus.out_valid === 1'b1) got.push_back(bus.out);
         @(negedge clk);
      end
      check("bp_drain_count", 32'(got.size()), 32'd3);
      for (int i = 0; i < 3; i++) begin
         if (i < got.size()) check("bp_drain_order", 32'(got[i]), 32'(bp[i]));
      end

      // Two-cycle enable drop mid-stagger delays the product by two cycles.
      tick();
      inject(8'h5A);
      tick();
      tick();
      bus.en = 1'b0;
      tick();
      tick();
      bus.en = 1'b1;
      wait_lat(4, 6, 8'h5A);

      // Reset with two queued products and one in flight.
      repeat (3) tick();
      bus.out_ready = 1'b0;
      inject(8'h90);
      tick();
      inject(8'h09);
      tick();
      inject(8'h66);
      repeat (8) tick();
      check("pre_rst_valid", 32'(bus.out_valid), 32'd1);
      clear_stim();
      rst = 1'b0;
      #1;
      check("rst_async_valid", 32'(bus.out_valid), 32'd0);
      tick();
      tick();
      rst           = 1'b1;
      bus.out_ready = 1'b1;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         tick();
         @(negedge clk);
         if (bus.out_valid !== 1'b0) seen++;
      end
      check("post_rst_quiet", 32'(seen), 32'd0);
      tick();
      inject(8'h77);
      wait_lat(0, 4, 8'h77);

      // LOW=1 instance: word goes straight into the queue.
      tick();
      bus2.in       = 2'b10;
      bus2.in_valid = 1'b1;
      tick();
      bus2.in       = 2'b01;
      bus2.in_valid = 1'b1;
      @(negedge clk);
      check("low1_valid_a", 32'(bus2.out_valid), 32'd1);
      check("low1_out_a", 32'(bus2.out), 32'd2);
      tick();
      bus2.in_valid = 1'b0;
      bus2.in       = 2'b11;
      @(negedge clk);
      check("low1_valid_b", 32'(bus2.out_valid), 32'd1);
      check("low1_out_b", 32'(bus2.out), 32'd1);
      tick();
      @(negedge clk);
      check("low1_empty", 32'(bus2.out_valid), 32'd0);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
